// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit.
// The HILO_DIV_EN build macro selects whether the DIV state and divider are used.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } hilo_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } hilo_state_t;

  localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/serial_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock.
// valid_o flags the edge that commits the final step; quotient/remainder are the step results.
module serial_divider
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        divByZero_o,
  output logic        valid_o
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q;
  logic [4:0]  cnt_q;
  logic        active_q;
  logic [32:0] remShift;

  // A successful subtract leaves a value below the divisor, so 32 bits hold it.
  always_comb begin
    remShift = {rem_q, quo_q[31]};
    rem_d    = remShift[31:0];
    quo_d    = {quo_q[30:0], 1'b0};
    if (remShift >= {1'b0, div_q}) begin
      rem_d = remShift[31:0] - div_q;
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= dividend_i;
      div_q    <= divisor_i;
    end else if (active_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
      if (valid_o) begin
        active_q <= 1'b0;
      end
    end
  end

  assign valid_o     = active_q && (cnt_q == LAST_STEP);
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
  assign divByZero_o = (div_q == 32'd0);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair: MULTU capture, MTHI/MTLO, MF read path and serial DIVU.
// Define HILO_DIV_EN to build the divide path; without it DIVU is a no-op.
module hilo_muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] r64,
  input  logic        mf_sel,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  hilo_op_t    opSel;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  assign opSel    = hilo_op_t'(op);
  assign hilo_out = mf_sel ? hi_q : lo_q;
  assign done     = done_q;

`ifdef HILO_DIV_EN

  hilo_state_t state_q;
  logic        busy_q, divZero_q;
  logic        divStart, divValid, divByZero;
  logic [31:0] divQuo, divRem;

  assign divStart = start && (state_q == ST_IDLE) && (opSel == OP_DIVU);

  serial_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (divStart),
    .dividend_i (a),
    .divisor_i  (b),
    .quotient_o (divQuo),
    .remainder_o(divRem),
    .divByZero_o(divByZero),
    .valid_o    (divValid)
  );

  // Starts arriving during DIV are dropped; the controller holds them on busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (opSel)
              OP_MULTU: begin
                hi_q   <= r64[63:32];
                lo_q   <= r64[31:0];
                done_q <= 1'b1;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              OP_DIVU: begin
                state_q <= ST_DIV;
                busy_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_DIV: begin
          if (divValid) begin
            hi_q      <= divRem;
            lo_q      <= divQuo;
            divZero_q <= divByZero;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign div_zero = divZero_q;

`else

  logic unusedDivisor;

  // Without a divider the unit never leaves IDLE, so only the single-cycle ops remain.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        case (opSel)
          OP_MULTU: begin
            hi_q   <= r64[63:32];
            lo_q   <= r64[31:0];
            done_q <= 1'b1;
          end
          OP_MTHI: hi_q <= a;
          OP_MTLO: lo_q <= a;
          default: ;
        endcase
      end
    end
  end

  assign busy          = 1'b0;
  assign div_zero      = 1'b0;
  assign unusedDivisor = ^b;

`endif

endmodule
